// File: rtl/uart_rx_display_mux.sv
// rtl/uart_rx_display_mux.sv - two-digit multiplexed display of the last received UART byte
// Optional `LEADING_ZERO_BLANK_EN darkens the high digit when its nibble is zero.
module uart_rx_display_mux #(
   parameter int REFRESH_CYCLES  = 25000,
   parameter int GUARD_CYCLES    = 16,
   parameter int ACTIVITY_CYCLES = 2500000
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_rx_dv,
   input  logic [7:0] i_rx_byte,
   output logic [3:0] o_binary_num,
   output logic [1:0] o_digit_sel,
   output logic       o_activity
);

   localparam int MAX_CYCLES = (REFRESH_CYCLES > GUARD_CYCLES) ? REFRESH_CYCLES : GUARD_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
   localparam int ACT_W      = $clog2(ACTIVITY_CYCLES + 1);

   localparam logic [CNT_W-1:0] REFRESH_LOAD = CNT_W'(REFRESH_CYCLES);
   localparam logic [CNT_W-1:0] GUARD_LOAD   = CNT_W'(GUARD_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
   localparam logic [ACT_W-1:0] ACT_LOAD     = ACT_W'(ACTIVITY_CYCLES);
   localparam logic [ACT_W-1:0] ACT_ONE      = ACT_W'(1);

   typedef enum logic [1:0] {
      LO_ON    = 2'd0,
      LO_GUARD = 2'd1,
      HI_ON    = 2'd2,
      HI_GUARD = 2'd3
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic             frame_latch;
   logic [1:0]       sel_next;
   logic [7:0]       r_shadow;
   logic [7:0]       r_disp;
   logic             r_seen;
   logic [ACT_W-1:0] act_cnt;

   always_comb begin
      state_next  = state;
      cnt_next    = cnt - CNT_ONE;
      frame_latch = 1'b0;
      if (cnt == CNT_ONE) begin
         case (state)
            LO_ON: begin
               state_next = LO_GUARD;
               cnt_next   = GUARD_LOAD;
            end
            LO_GUARD: begin
               state_next = HI_ON;
               cnt_next   = REFRESH_LOAD;
            end
            HI_ON: begin
               state_next  = HI_GUARD;
               cnt_next    = GUARD_LOAD;
               frame_latch = 1'b1;
            end
            default: begin
               state_next = LO_ON;
               cnt_next   = REFRESH_LOAD;
            end
         endcase
      end
   end

   // Digit enable lags the state by one cycle, so the nibble (loaded during the
   // first guard cycle) is already decoded before the next ON window opens.
   always_comb begin
      sel_next = 2'b00;
      case (state)
         LO_ON: sel_next = 2'b01;
         HI_ON: begin
`ifdef LEADING_ZERO_BLANK_EN
            sel_next = (r_disp[7:4] == 4'h0) ? 2'b00 : 2'b10;
`else
            sel_next = 2'b10;
`endif
         end
         default: sel_next = 2'b00;
      endcase
      if (!r_seen) begin
         sel_next = 2'b00;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state        <= LO_ON;
         cnt          <= REFRESH_LOAD;
         r_shadow     <= 8'h00;
         r_disp       <= 8'h00;
         r_seen       <= 1'b0;
         o_binary_num <= 4'h0;
         o_digit_sel  <= 2'b00;
         act_cnt      <= '0;
      end else begin
         state       <= state_next;
         cnt         <= cnt_next;
         o_digit_sel <= sel_next;
         if (i_rx_dv) begin
            r_shadow <= i_rx_byte;
            r_seen   <= 1'b1;
         end
         if (frame_latch) begin
            r_disp <= r_shadow;
         end
         if (state == LO_GUARD) begin
            o_binary_num <= r_disp[7:4];
         end else if (state == HI_GUARD) begin
            o_binary_num <= r_disp[3:0];
         end
         if (i_rx_dv) begin
            act_cnt <= ACT_LOAD;
         end else if (act_cnt != '0) begin
            act_cnt <= act_cnt - ACT_ONE;
         end
      end
   end

   assign o_activity = (act_cnt != '0);

endmodule

// File: tb/tb_uart_rx_display_mux.sv
// tb/tb_uart_rx_display_mux.sv - scoreboard bench for uart_rx_display_mux
// Build with or without LEADING_ZERO_BLANK_EN to match the DUT.
module tb_uart_rx_display_mux;

   localparam int R = 8;
   localparam int G = 2;
   localparam int A = 20;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_dv = 1'b0;
   logic [7:0] rx_byte = 8'h00;
   logic [3:0] binary_num;
   logic [1:0] digit_sel;
   logic       activity;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];

   uart_rx_display_mux #(
      .REFRESH_CYCLES (R),
      .GUARD_CYCLES   (G),
      .ACTIVITY_CYCLES(A)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_rx_dv     (rx_dv),
      .i_rx_byte   (rx_byte),
      .o_binary_num(binary_num),
      .o_digit_sel (digit_sel),
      .o_activity  (activity)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit push);
      rx_dv   = 1'b1;
      rx_byte = b;
      if (push) exp_q.push_back(b);
      @(negedge clk);
      rx_dv = 1'b0;
   endtask

   task automatic wait_sel(input logic [1:0] val, input string tag);
      int n = 0;
      while (digit_sel !== val && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_val(tag, {30'd0, digit_sel}, {30'd0, val});
   endtask

   task automatic next_full_lo(input string tag);
      for (int k = 0; k < 2; k++) begin
         wait_sel(2'b00, {tag, "_gap"});
         wait_sel(2'b01, {tag, "_lo"});
      end
   endtask

   // Walks one LO visit, the following dark run, and an HI visit if present.
   task automatic capture(output logic [3:0] lo, output logic [3:0] hi,
                          output int lo_len, output int gap, output int hi_len,
                          output int glitches);
      lo = binary_num; hi = 4'h0;
      lo_len = 0; gap = 0; hi_len = 0; glitches = 0;
      while (digit_sel == 2'b01 && lo_len < 50) begin
         if (binary_num !== lo) glitches++;
         lo_len++;
         @(negedge clk);
      end
      while (digit_sel == 2'b00 && gap < 50) begin
         gap++;
         @(negedge clk);
      end
      hi = binary_num;
      while (digit_sel == 2'b10 && hi_len < 50) begin
         if (binary_num !== hi) glitches++;
         hi_len++;
         @(negedge clk);
      end
   endtask

   task automatic pop_frame(input string tag, input logic [3:0] lo, input logic [3:0] hi);
      logic [7:0] e;
      check_val({tag, "_queued"}, exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check_val({tag, "_lo"}, lo, e[3:0]);
         check_val({tag, "_hi"}, hi, e[7:4]);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      logic [3:0] lo, hi;
      int lo_len, gap, hi_len, glitches;
      int bad_sel, bad_num, bad_act;

      tick(3);
      check_val("rst_sel", digit_sel, 2'b00);
      check_val("rst_num", binary_num, 4'h0);
      check_val("rst_act", activity, 1'b0);
      rst = 1'b0;

      bad_sel = 0; bad_num = 0; bad_act = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (digit_sel !== 2'b00) bad_sel++;
         if (binary_num !== 4'h0) bad_num++;
         if (activity !== 1'b0) bad_act++;
      end
      check_val("idle_sel", bad_sel, 0);
      check_val("idle_num", bad_num, 0);
      check_val("idle_act", bad_act, 0);

      check_val("act_t0", activity, 1'b0);
      send_byte(8'hA5, 1);
      check_val("act_t1", activity, 1'b1);
      tick(9);
      check_val("act_t10", activity, 1'b1);
      send_byte(8'hA5, 1);
      tick(19);
      check_val("act_t30", activity, 1'b1);
      tick(1);
      check_val("act_t31", activity, 1'b0);

      next_full_lo("a5");
      capture(lo, hi, lo_len, gap, hi_len, glitches);
      pop_frame("a5", lo, hi);
      check_val("a5_lo_len", lo_len, R);
      check_val("a5_gap", gap, G);
      check_val("a5_hi_len", hi_len, R);
      check_val("a5_glitch", glitches, 0);

      wait_sel(2'b01, "mid_lo");
      send_byte(8'h3C, 1);
      capture(lo, hi, lo_len, gap, hi_len, glitches);
      pop_frame("mid_cur", lo, hi);
      check_val("mid_cur_glitch", glitches, 0);
      wait_sel(2'b01, "mid_next_lo");
      capture(lo, hi, lo_len, gap, hi_len, glitches);
      pop_frame("mid_next", lo, hi);
      check_val("mid_next_lo_len", lo_len, R);

      send_byte(8'h07, 1);
      next_full_lo("lz");
      capture(lo, hi, lo_len, gap, hi_len, glitches);
      pop_frame("lz", lo, hi);
`ifdef LEADING_ZERO_BLANK_EN
      check_val("lz_dark_run", gap, G + R + G);
      check_val("lz_hi_len", hi_len, 0);
`else
      check_val("lz_gap", gap, G);
      check_val("lz_hi_len", hi_len, R);
`endif

      send_byte(8'hA5, 0);
      next_full_lo("rs");
      wait_sel(2'b10, "rs_hi_on");
      check_val("rs_hi_num", binary_num, 4'hA);
      rst     = 1'b1;
      rx_dv   = 1'b1;
      rx_byte = 8'hFF;
      @(negedge clk);
      rst   = 1'b0;
      rx_dv = 1'b0;
      check_val("rs_sel", digit_sel, 2'b00);
      check_val("rs_num", binary_num, 4'h0);
      check_val("rs_act", activity, 1'b0);
      bad_sel = 0; bad_num = 0; bad_act = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (digit_sel !== 2'b00) bad_sel++;
         if (binary_num !== 4'h0) bad_num++;
         if (activity !== 1'b0) bad_act++;
      end
      check_val("rs_blank_sel", bad_sel, 0);
      check_val("rs_blank_num", bad_num, 0);
      check_val("rs_blank_act", bad_act, 0);
      check_val("queue_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
